// File: rtl/unload_sequencer.sv
// unload_sequencer: drives N_STAGES one-hot unload strobes in ascending order.
// Each strobe stays high for a dwell latched at start, and consecutive strobes
// are separated by GAP_CYCLES all-low cycles. The block offers a start/busy/done
// handshake and a synchronous abort. Every output comes straight from a register.
module unload_sequencer #(
    parameter int N_STAGES   = 3,
    parameter int DWELL_W    = 4,
    parameter int GAP_CYCLES = 1,
    parameter int STAGE_W    = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [DWELL_W-1:0]  dwell,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [N_STAGES-1:0] unload,
    output logic [STAGE_W-1:0]  stage_idx
);

    // The gap counter counts 0..GAP_CYCLES-1, so it never has to wrap.
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [GAP_W-1:0]   GAP_ZERO   = GAP_W'(0);
    localparam logic [GAP_W-1:0]   GAP_ONE    = GAP_W'(1);
    localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(N_STAGES - 1);
    localparam logic [STAGE_W-1:0] STAGE_ZERO = STAGE_W'(0);
    localparam logic [STAGE_W-1:0] STAGE_ONE  = STAGE_W'(1);
    localparam logic [DWELL_W-1:0] DWELL_ZERO = DWELL_W'(0);
    localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UNLOAD = 2'd1,
        ST_GAP    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [DWELL_W-1:0]  dwell_r;
    logic [DWELL_W-1:0]  dwell_s;
    logic [DWELL_W-1:0]  cnt_r;
    logic [DWELL_W-1:0]  cnt_s;
    logic [GAP_W-1:0]    gap_cnt_r;
    logic [GAP_W-1:0]    gap_cnt_s;
    logic [STAGE_W-1:0]  stage_r;
    logic [STAGE_W-1:0]  stage_s;
    logic                done_s;
    logic                aborted_s;
    logic [N_STAGES-1:0] unload_s;
    logic                busy_s;
    logic [N_STAGES-1:0] unload_r;
    logic                busy_r;
    logic                done_r;
    logic                aborted_r;

    // Decode a stage index into its one-hot strobe pattern.
    function automatic logic [N_STAGES-1:0] stage_onehot(input logic [STAGE_W-1:0] idx);
        logic [N_STAGES-1:0] oh;
        oh = '0;
        for (int i = 0; i < N_STAGES; i++) begin
            if (idx == STAGE_W'(i)) begin
                oh[i] = 1'b1;
            end else begin
                oh[i] = 1'b0;
            end
        end
        return oh;
    endfunction

    // Next-state, counter and pulse decisions for the sequencer.
    always_comb begin
        state_s   = state_r;
        dwell_s   = dwell_r;
        cnt_s     = cnt_r;
        gap_cnt_s = gap_cnt_r;
        stage_s   = stage_r;
        done_s    = 1'b0;
        aborted_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // A simultaneous abort blocks the start.
                if (start && !abort) begin
                    dwell_s   = (dwell == DWELL_ZERO) ? DWELL_ONE : dwell;
                    stage_s   = STAGE_ZERO;
                    cnt_s     = DWELL_ZERO;
                    gap_cnt_s = GAP_ZERO;
                    state_s   = ST_UNLOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_UNLOAD: begin
                if (abort) begin
                    state_s   = ST_IDLE;
                    aborted_s = 1'b1;
                    cnt_s     = DWELL_ZERO;
                end else if (cnt_r == (dwell_r - DWELL_ONE)) begin
                    cnt_s = DWELL_ZERO;
                    if (stage_r == STAGE_LAST) begin
                        state_s = ST_DONE;
                        done_s  = 1'b1;
                    end else if (GAP_CYCLES > 0) begin
                        state_s   = ST_GAP;
                        gap_cnt_s = GAP_ZERO;
                    end else begin
                        // No gap: the next strobe follows immediately.
                        stage_s = stage_r + STAGE_ONE;
                        state_s = ST_UNLOAD;
                    end
                end else begin
                    cnt_s = cnt_r + DWELL_ONE;
                end
            end
            ST_GAP: begin
                if (abort) begin
                    state_s   = ST_IDLE;
                    aborted_s = 1'b1;
                    gap_cnt_s = GAP_ZERO;
                end else if (gap_cnt_r == GAP_LAST) begin
                    gap_cnt_s = GAP_ZERO;
                    stage_s   = stage_r + STAGE_ONE;
                    cnt_s     = DWELL_ZERO;
                    state_s   = ST_UNLOAD;
                end else begin
                    gap_cnt_s = gap_cnt_r + GAP_ONE;
                end
            end
            ST_DONE: begin
                // Start is only sampled in IDLE, so a held start restarts one cycle later.
                state_s = ST_IDLE;
            end
            default: begin
                state_s   = ST_IDLE;
                cnt_s     = DWELL_ZERO;
                gap_cnt_s = GAP_ZERO;
            end
        endcase
    end

    // Output values are computed from the next state so that the registers line up with it.
    always_comb begin
        unload_s = '0;
        busy_s   = 1'b0;
        if (state_s == ST_UNLOAD) begin
            unload_s = stage_onehot(stage_s);
        end else begin
            unload_s = '0;
        end
        if (state_s != ST_IDLE) begin
            busy_s = 1'b1;
        end else begin
            busy_s = 1'b0;
        end
    end

    // State, counter and latched-dwell registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            dwell_r   <= DWELL_ZERO;
            cnt_r     <= DWELL_ZERO;
            gap_cnt_r <= GAP_ZERO;
            stage_r   <= STAGE_ZERO;
        end else begin
            state_r   <= state_s;
            dwell_r   <= dwell_s;
            cnt_r     <= cnt_s;
            gap_cnt_r <= gap_cnt_s;
            stage_r   <= stage_s;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            unload_r  <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            aborted_r <= 1'b0;
        end else begin
            unload_r  <= unload_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            aborted_r <= aborted_s;
        end
    end

    assign unload    = unload_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign aborted   = aborted_r;
    assign stage_idx = stage_r;

endmodule
